// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register, with load-use stall detection.
// Define ID_WB_BYPASS_EN to bypass the WB write data into operands read in the same cycle.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_instr,
    output logic [4:0]       rd_reg1,
    output logic [4:0]       rd_reg2,
    input  logic [31:0]      DAT1,
    input  logic [31:0]      DAT2,
    input  logic             wb_reg_wr,
    input  logic [4:0]       wb_wr_reg,
    input  logic [31:0]      wb_wr_data,
    input  logic             ex_flush,
    output logic             stall_if,
    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_rs1_data,
    output logic [31:0]      ex_rs2_data,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [6:0]       ex_opcode,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic             ex_reg_wr,
    output logic             ex_mem_rd,
    output logic             ex_mem_wr,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [6:0]       opcode;
    logic [4:0]       rs1, rs2, rd;
    logic [31:0]      imm_d, rs1_data_d, rs2_data_d;
    logic             reg_wr_dec, mem_rd_dec, mem_wr_dec, rs1_used, rs2_used;
    logic             load_use, kill;
    logic             valid_d, reg_wr_d, mem_rd_d, mem_wr_d;
    logic [CNT_W-1:0] cnt_d;

    logic             valid_q, funct7b5_q, reg_wr_q, mem_rd_q, mem_wr_q;
    logic [31:0]      pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic [CNT_W-1:0] cnt_q;

    assign opcode  = id_instr[6:0];
    assign rd      = id_instr[11:7];
    assign rs1     = id_instr[19:15];
    assign rs2     = id_instr[24:20];
    assign rd_reg1 = rs1;
    assign rd_reg2 = rs2;

    always_comb begin
        imm_d      = '0;
        reg_wr_dec = 1'b0;
        mem_rd_dec = 1'b0;
        mem_wr_dec = 1'b0;
        rs1_used   = 1'b1;
        rs2_used   = 1'b0;
        case (opcode)
            OP_LOAD: begin
                imm_d      = {{20{id_instr[31]}}, id_instr[31:20]};
                reg_wr_dec = 1'b1;
                mem_rd_dec = 1'b1;
            end
            OP_IMM, OP_JALR: begin
                imm_d      = {{20{id_instr[31]}}, id_instr[31:20]};
                reg_wr_dec = 1'b1;
            end
            OP_STORE: begin
                imm_d      = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
                mem_wr_dec = 1'b1;
                rs2_used   = 1'b1;
            end
            OP_BRANCH: begin
                imm_d    = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                            id_instr[30:25], id_instr[11:8], 1'b0};
                rs2_used = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_d      = {id_instr[31:12], 12'b0};
                reg_wr_dec = 1'b1;
                rs1_used   = 1'b0;
            end
            OP_JAL: begin
                imm_d      = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                              id_instr[20], id_instr[30:21], 1'b0};
                reg_wr_dec = 1'b1;
                rs1_used   = 1'b0;
            end
            OP_REG: begin
                reg_wr_dec = 1'b1;
                rs2_used   = 1'b1;
            end
            default: ;
        endcase
        // The register file does not hardwire x0, so writes to it are suppressed here.
        if (rd == 5'd0) reg_wr_dec = 1'b0;
    end

`ifdef ID_WB_BYPASS_EN
    logic byp1, byp2;
    assign byp1       = wb_reg_wr && (wb_wr_reg != 5'd0) && (wb_wr_reg == rs1);
    assign byp2       = wb_reg_wr && (wb_wr_reg != 5'd0) && (wb_wr_reg == rs2);
    assign rs1_data_d = (rs1 == 5'd0) ? '0 : (byp1 ? wb_wr_data : DAT1);
    assign rs2_data_d = (rs2 == 5'd0) ? '0 : (byp2 ? wb_wr_data : DAT2);
`else
    logic unused_wb;
    assign unused_wb  = ^{wb_reg_wr, wb_wr_reg, wb_wr_data};
    assign rs1_data_d = (rs1 == 5'd0) ? '0 : DAT1;
    assign rs2_data_d = (rs2 == 5'd0) ? '0 : DAT2;
`endif

    assign load_use = valid_q && mem_rd_q && (rd_q != 5'd0) && id_valid &&
                      ((rs1_used && (rs1 == rd_q)) || (rs2_used && (rs2 == rd_q)));
    // A flush kills the dependent instruction anyway, so it never needs to stall.
    assign stall_if = load_use && !ex_flush;
    assign kill     = load_use || ex_flush;
    assign valid_d  = id_valid && !kill;
    assign reg_wr_d = reg_wr_dec && !kill;
    assign mem_rd_d = mem_rd_dec && !kill;
    assign mem_wr_d = mem_wr_dec && !kill;
    assign cnt_d    = (stall_if && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            reg_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= id_pc;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1;
            rs2_q      <= rs2;
            rd_q       <= rd;
            opcode_q   <= opcode;
            funct3_q   <= id_instr[14:12];
            funct7b5_q <= id_instr[30];
            reg_wr_q   <= reg_wr_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_opcode   = opcode_q;
    assign ex_funct3   = funct3_q;
    assign ex_funct7b5 = funct7b5_q;
    assign ex_reg_wr   = reg_wr_q;
    assign ex_mem_rd   = mem_rd_q;
    assign ex_mem_wr   = mem_wr_q;
    assign stall_cnt   = cnt_q;
endmodule
